// File: rtl/hyperbus_cmd_seq.sv
// rtl/hyperbus_cmd_seq.sv - HyperBus transaction sequencer: CS, CA word, latency, data phase, CS timing
module hyperbus_cmd_seq #(
    parameter int NumChips        = 2,
    parameter int LenWidth        = 8,
    parameter int TimeoutCycles   = 64,
    parameter int CsMinHighCycles = 4,
    localparam int CsW            = (NumChips > 1) ? $clog2(NumChips) : 1
) (
    input  logic                clk_phy_i,
    input  logic                rst_ni,
    input  logic [3:0]          cfg_latency_i,
    input  logic                cfg_latency_fixed_i,
    input  logic                trans_valid_i,
    output logic                trans_ready_o,
    input  logic                trans_write_i,
    input  logic                trans_addr_space_i,
    input  logic                trans_burst_linear_i,
    input  logic [31:0]         trans_addr_i,
    input  logic [LenWidth-1:0] trans_len_i,
    input  logic [CsW-1:0]      trans_cs_sel_i,
    input  logic                tx_valid_i,
    output logic                tx_ready_o,
    input  logic [7:0]          tx_data_i,
    input  logic                tx_mask_i,
    input  logic                rx_valid_i,
    input  logic [7:0]          rx_data_i,
    output logic                rx_valid_o,
    output logic [7:0]          rx_data_o,
    output logic                rx_last_o,
    output logic                done_o,
    output logic                done_error_o,
    output logic [NumChips-1:0] hyper_cs_no,
    output logic                hyper_ck_en_o,
    output logic [7:0]          hyper_dq_o,
    output logic                hyper_dq_oe_o,
    output logic                hyper_rwds_o,
    output logic                hyper_rwds_oe_o,
    input  logic                hyper_rwds_i,
    output logic [3:0]          debug_state_o
);

    localparam int BcW    = LenWidth + 2;
    localparam int TmrMax = (TimeoutCycles > CsMinHighCycles) ? TimeoutCycles : CsMinHighCycles;
    localparam int TmrW   = $clog2(TmrMax + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CS_SETUP   = 3'd1,
        CA         = 3'd2,
        LATENCY    = 3'd3,
        WDATA      = 3'd4,
        RDATA      = 3'd5,
        CS_HOLD    = 3'd6,
        CS_RECOVER = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic [47:0]    ca_q, ca_d;
    logic           write_q, write_d;
    logic           space_q, space_d;
    logic [CsW-1:0] cs_sel_q, cs_sel_d;
    logic [BcW-1:0] byte_cnt_q, byte_cnt_d;
    logic [5:0]     lat_q, lat_d;
    logic           dbl_q, dbl_d;
    logic           err_q, err_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [7:0]     dq_q, dq_d;
    logic           mask_q, mask_d;

    logic [5:0]          lat_w;
    logic                cs_act;
    logic                ready_c;
    logic [NumChips-1:0] cs_onehot;

    assign cs_onehot     = NumChips'(1) << cs_sel_q;
    assign hyper_cs_no   = cs_act ? ~cs_onehot : '1;
    assign trans_ready_o = ready_c & rst_ni;
    assign debug_state_o = {1'b0, state_q};
    assign lat_w         = dbl_q ? {cfg_latency_i, 2'b00} : {1'b0, cfg_latency_i, 1'b0};

    always_comb begin
        state_d         = state_q;
        ca_d            = ca_q;
        write_d         = write_q;
        space_d         = space_q;
        cs_sel_d        = cs_sel_q;
        byte_cnt_d      = byte_cnt_q;
        lat_d           = lat_q;
        dbl_d           = dbl_q;
        err_d           = err_q;
        tmr_d           = tmr_q;
        dq_d            = dq_q;
        mask_d          = mask_q;
        ready_c         = 1'b0;
        cs_act          = 1'b0;
        tx_ready_o      = 1'b0;
        rx_valid_o      = 1'b0;
        rx_data_o       = 8'h00;
        rx_last_o       = 1'b0;
        done_o          = 1'b0;
        done_error_o    = 1'b0;
        hyper_ck_en_o   = 1'b0;
        hyper_dq_o      = 8'h00;
        hyper_dq_oe_o   = 1'b0;
        hyper_rwds_o    = 1'b0;
        hyper_rwds_oe_o = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (trans_valid_i) begin
                    ca_d       = {~trans_write_i, trans_addr_space_i, trans_burst_linear_i,
                                  trans_addr_i[31:3], 13'd0, trans_addr_i[2:0]};
                    write_d    = trans_write_i;
                    space_d    = trans_addr_space_i;
                    cs_sel_d   = trans_cs_sel_i;
                    byte_cnt_d = ({2'b00, trans_len_i} + BcW'(1)) << 1;
                    lat_d      = 6'd0;
                    dbl_d      = 1'b0;
                    err_d      = 1'b0;
                    state_d    = CS_SETUP;
                end
            end
            CS_SETUP: begin
                cs_act  = 1'b1;
                lat_d   = 6'd0;
                state_d = CA;
            end
            CA: begin
                cs_act        = 1'b1;
                hyper_dq_oe_o = 1'b1;
                hyper_ck_en_o = 1'b1;
                case (lat_q[2:0])
                    3'd0:    hyper_dq_o = ca_q[47:40];
                    3'd1:    hyper_dq_o = ca_q[39:32];
                    3'd2:    hyper_dq_o = ca_q[31:24];
                    3'd3:    hyper_dq_o = ca_q[23:16];
                    3'd4:    hyper_dq_o = ca_q[15:8];
                    default: hyper_dq_o = ca_q[7:0];
                endcase
                if (lat_q == 6'd2) begin
                    dbl_d = hyper_rwds_i | cfg_latency_fixed_i;
                end
                if (lat_q == 6'd5) begin
                    tmr_d = '0;
                    // Register writes carry no initial latency regardless of RWDS.
                    if (write_q && space_q) begin
                        state_d = WDATA;
                    end else if (lat_w == 6'd0) begin
                        state_d = write_q ? WDATA : RDATA;
                    end else begin
                        lat_d   = lat_w;
                        state_d = LATENCY;
                    end
                end else begin
                    lat_d = lat_q + 6'd1;
                end
            end
            LATENCY: begin
                cs_act        = 1'b1;
                hyper_ck_en_o = 1'b1;
                tmr_d         = '0;
                lat_d         = lat_q - 6'd1;
                if (lat_q == 6'd1) begin
                    state_d = write_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                cs_act          = 1'b1;
                tx_ready_o      = 1'b1;
                hyper_dq_oe_o   = 1'b1;
                hyper_rwds_oe_o = ~space_q;
                hyper_dq_o      = dq_q;
                hyper_rwds_o    = mask_q;
                if (tx_valid_i) begin
                    hyper_ck_en_o = 1'b1;
                    hyper_dq_o    = tx_data_i;
                    hyper_rwds_o  = tx_mask_i;
                    dq_d          = tx_data_i;
                    mask_d        = tx_mask_i;
                    byte_cnt_d    = byte_cnt_q - BcW'(1);
                    if (byte_cnt_q == BcW'(1)) begin
                        state_d = CS_HOLD;
                    end
                end
            end
            RDATA: begin
                cs_act        = 1'b1;
                hyper_ck_en_o = 1'b1;
                if (rx_valid_i) begin
                    rx_valid_o = 1'b1;
                    rx_data_o  = rx_data_i;
                    rx_last_o  = (byte_cnt_q == BcW'(1));
                    byte_cnt_d = byte_cnt_q - BcW'(1);
                    tmr_d      = '0;
                    if (byte_cnt_q == BcW'(1)) begin
                        state_d = CS_HOLD;
                    end
                end else if (tmr_q == TmrW'(TimeoutCycles - 1)) begin
                    err_d   = 1'b1;
                    state_d = CS_HOLD;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            CS_HOLD: begin
                cs_act       = 1'b1;
                done_o       = 1'b1;
                done_error_o = err_q;
                tmr_d        = '0;
                state_d      = CS_RECOVER;
            end
            default: begin
                if (tmr_q == TmrW'(CsMinHighCycles - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_phy_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ca_q       <= '0;
            write_q    <= 1'b0;
            space_q    <= 1'b0;
            cs_sel_q   <= '0;
            byte_cnt_q <= '0;
            lat_q      <= '0;
            dbl_q      <= 1'b0;
            err_q      <= 1'b0;
            tmr_q      <= '0;
            dq_q       <= '0;
            mask_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ca_q       <= ca_d;
            write_q    <= write_d;
            space_q    <= space_d;
            cs_sel_q   <= cs_sel_d;
            byte_cnt_q <= byte_cnt_d;
            lat_q      <= lat_d;
            dbl_q      <= dbl_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
            dq_q       <= dq_d;
            mask_q     <= mask_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_cmd_seq.sv
// tb/tb_hyperbus_cmd_seq.sv - directed self-checking bench for hyperbus_cmd_seq
module tb_hyperbus_cmd_seq;

    logic       clk_phy_i = 1'b0;
    logic       rst_ni;
    logic [3:0] cfg_latency_i;
    logic       cfg_latency_fixed_i;
    logic       trans_valid_i;
    logic       trans_ready_o;
    logic       trans_write_i;
    logic       trans_addr_space_i;
    logic       trans_burst_linear_i;
    logic [31:0] trans_addr_i;
    logic [7:0] trans_len_i;
    logic       trans_cs_sel_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] tx_data_i;
    logic       tx_mask_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_o;
    logic [7:0] rx_data_o;
    logic       rx_last_o;
    logic       done_o;
    logic       done_error_o;
    logic [1:0] hyper_cs_no;
    logic       hyper_ck_en_o;
    logic [7:0] hyper_dq_o;
    logic       hyper_dq_oe_o;
    logic       hyper_rwds_o;
    logic       hyper_rwds_oe_o;
    logic       hyper_rwds_i;
    logic [3:0] debug_state_o;

    int errors = 0;
    int checks = 0;

    hyperbus_cmd_seq dut (
        .clk_phy_i            (clk_phy_i),
        .rst_ni               (rst_ni),
        .cfg_latency_i        (cfg_latency_i),
        .cfg_latency_fixed_i  (cfg_latency_fixed_i),
        .trans_valid_i        (trans_valid_i),
        .trans_ready_o        (trans_ready_o),
        .trans_write_i        (trans_write_i),
        .trans_addr_space_i   (trans_addr_space_i),
        .trans_burst_linear_i (trans_burst_linear_i),
        .trans_addr_i         (trans_addr_i),
        .trans_len_i          (trans_len_i),
        .trans_cs_sel_i       (trans_cs_sel_i),
        .tx_valid_i           (tx_valid_i),
        .tx_ready_o           (tx_ready_o),
        .tx_data_i            (tx_data_i),
        .tx_mask_i            (tx_mask_i),
        .rx_valid_i           (rx_valid_i),
        .rx_data_i            (rx_data_i),
        .rx_valid_o           (rx_valid_o),
        .rx_data_o            (rx_data_o),
        .rx_last_o            (rx_last_o),
        .done_o               (done_o),
        .done_error_o         (done_error_o),
        .hyper_cs_no          (hyper_cs_no),
        .hyper_ck_en_o        (hyper_ck_en_o),
        .hyper_dq_o           (hyper_dq_o),
        .hyper_dq_oe_o        (hyper_dq_oe_o),
        .hyper_rwds_o         (hyper_rwds_o),
        .hyper_rwds_oe_o      (hyper_rwds_oe_o),
        .hyper_rwds_i         (hyper_rwds_i),
        .debug_state_o        (debug_state_o)
    );

    always #5 clk_phy_i = ~clk_phy_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic count_state(input logic [3:0] s, output int n);
        n = 0;
        while (debug_state_o == s && n < 200) begin
            n++;
            @(negedge clk_phy_i);
        end
    endtask

    task automatic start_trans(input logic w, input logic sp, input logic [31:0] addr,
                               input logic [7:0] len, input logic cs);
        trans_write_i        = w;
        trans_addr_space_i   = sp;
        trans_burst_linear_i = 1'b1;
        trans_addr_i         = addr;
        trans_len_i          = len;
        trans_cs_sel_i       = cs;
        trans_valid_i        = 1'b1;
        check_eq("idle_ready", {31'd0, trans_ready_o}, 32'd1);
        @(posedge clk_phy_i);
        #1 trans_valid_i = 1'b0;
        @(negedge clk_phy_i);
        check_eq("setup_state", {28'd0, debug_state_o}, 32'd1);
        check_eq("setup_cs", {30'd0, hyper_cs_no}, cs ? 32'd1 : 32'd2);
        check_eq("setup_drive", {30'd0, hyper_ck_en_o, hyper_dq_oe_o}, 32'd0);
        @(negedge clk_phy_i);
    endtask

    task automatic check_ca(input logic [47:0] ca, input logic rwds2);
        logic [47:0] sh;
        sh = ca;
        for (int k = 0; k < 6; k++) begin
            check_eq("ca_state", {28'd0, debug_state_o}, 32'd2);
            check_eq("ca_byte", {24'd0, hyper_dq_o}, {24'd0, sh[47:40]});
            check_eq("ca_drive", {30'd0, hyper_ck_en_o, hyper_dq_oe_o}, 32'd3);
            if (k == 2) hyper_rwds_i = rwds2;
            @(negedge clk_phy_i);
            hyper_rwds_i = 1'b0;
            sh = sh << 8;
        end
    endtask

    task automatic finish_trans(input logic exp_err);
        int n;
        check_eq("hold_state", {28'd0, debug_state_o}, 32'd6);
        check_eq("hold_done", {30'd0, done_o, done_error_o}, {30'd0, 1'b1, exp_err});
        check_eq("hold_cs_low", {31'd0, &hyper_cs_no}, 32'd0);
        check_eq("hold_ck_en", {31'd0, hyper_ck_en_o}, 32'd0);
        @(negedge clk_phy_i);
        check_eq("recover_cs", {30'd0, hyper_cs_no}, 32'd3);
        check_eq("recover_ready", {31'd0, trans_ready_o}, 32'd0);
        count_state(4'd7, n);
        check_eq("recover_len", n, 32'd4);
        check_eq("back_idle", {28'd0, debug_state_o}, 32'd0);
    endtask

    task automatic run_read(input logic rwds2, input logic fixed, input int exp_lat);
        int n;
        cfg_latency_i       = 4'd6;
        cfg_latency_fixed_i = fixed;
        start_trans(1'b0, 1'b0, 32'h0000_1235, 8'd1, 1'b0);
        check_ca(48'hA000_0246_0005, rwds2);
        count_state(4'd3, n);
        check_eq("latency_len", n, exp_lat);
        for (int i = 0; i < 4; i++) begin
            check_eq("rd_state", {28'd0, debug_state_o}, 32'd5);
            rx_valid_i = 1'b1;
            rx_data_i  = 8'h10 + 8'(i);
            #1;
            check_eq("rd_valid", {31'd0, rx_valid_o}, 32'd1);
            check_eq("rd_data", {24'd0, rx_data_o}, 32'h10 + i);
            check_eq("rd_last", {31'd0, rx_last_o}, (i == 3) ? 32'd1 : 32'd0);
            @(negedge clk_phy_i);
            rx_valid_i = 1'b0;
        end
        finish_trans(1'b0);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0;
        cfg_latency_i = 4'd6; cfg_latency_fixed_i = 1'b0;
        trans_valid_i = 1'b0; trans_write_i = 1'b0; trans_addr_space_i = 1'b0;
        trans_burst_linear_i = 1'b0; trans_addr_i = '0; trans_len_i = '0; trans_cs_sel_i = 1'b0;
        tx_valid_i = 1'b0; tx_data_i = '0; tx_mask_i = 1'b0;
        rx_valid_i = 1'b0; rx_data_i = '0; hyper_rwds_i = 1'b0;
        repeat (3) @(negedge clk_phy_i);
        check_eq("rst_cs", {30'd0, hyper_cs_no}, 32'd3);
        check_eq("rst_ready", {31'd0, trans_ready_o}, 32'd0);
        check_eq("rst_outs", {27'd0, done_o, hyper_ck_en_o, hyper_dq_oe_o, hyper_rwds_oe_o, tx_ready_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_phy_i);
        check_eq("rst_release_ready", {31'd0, trans_ready_o}, 32'd1);

        run_read(1'b0, 1'b0, 12);
        run_read(1'b1, 1'b0, 24);
        run_read(1'b0, 1'b1, 24);
        cfg_latency_fixed_i = 1'b0;

        // memory write, len 0, 3-cycle tx gap between the two bytes
        start_trans(1'b1, 1'b0, 32'h0000_0008, 8'd0, 1'b1);
        check_ca(48'h2000_0001_0000, 1'b0);
        count_state(4'd3, n);
        check_eq("wr_latency_len", n, 32'd12);
        tx_valid_i = 1'b1; tx_data_i = 8'h5A; tx_mask_i = 1'b1;
        #1;
        check_eq("wr0_state", {28'd0, debug_state_o}, 32'd4);
        check_eq("wr0_ready", {31'd0, tx_ready_o}, 32'd1);
        check_eq("wr0_dq", {24'd0, hyper_dq_o}, 32'h5A);
        check_eq("wr0_drive", {29'd0, hyper_ck_en_o, hyper_dq_oe_o, hyper_rwds_oe_o}, 32'd7);
        check_eq("wr0_rwds", {31'd0, hyper_rwds_o}, 32'd1);
        @(negedge clk_phy_i);
        tx_valid_i = 1'b0; tx_data_i = 8'hFF; tx_mask_i = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
            check_eq("gap_state", {28'd0, debug_state_o}, 32'd4);
            check_eq("gap_ck_en", {31'd0, hyper_ck_en_o}, 32'd0);
            check_eq("gap_dq_held", {24'd0, hyper_dq_o}, 32'h5A);
            @(negedge clk_phy_i);
        end
        tx_valid_i = 1'b1; tx_data_i = 8'hC3; tx_mask_i = 1'b0;
        #1;
        check_eq("wr1_dq", {24'd0, hyper_dq_o}, 32'hC3);
        check_eq("wr1_rwds", {30'd0, hyper_rwds_oe_o, hyper_rwds_o}, 32'd2);
        check_eq("wr1_ck_en", {31'd0, hyper_ck_en_o}, 32'd1);
        @(negedge clk_phy_i);
        tx_valid_i = 1'b0;
        finish_trans(1'b0);

        // register write: no latency, rwds not driven
        start_trans(1'b1, 1'b1, 32'h0000_0001, 8'd0, 1'b1);
        check_ca(48'h6000_0000_0001, 1'b1);
        check_eq("reg_wdata_now", {28'd0, debug_state_o}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            tx_valid_i = 1'b1; tx_data_i = 8'hA0 + 8'(i); tx_mask_i = 1'b1;
            #1;
            check_eq("reg_dq", {24'd0, hyper_dq_o}, 32'hA0 + i);
            check_eq("reg_rwds_oe", {31'd0, hyper_rwds_oe_o}, 32'd0);
            @(negedge clk_phy_i);
        end
        tx_valid_i = 1'b0; tx_mask_i = 1'b0;
        finish_trans(1'b0);

        // read timeout: len 3, two bytes then silence
        cfg_latency_i = 4'd1;
        start_trans(1'b0, 1'b0, 32'h0000_0000, 8'd3, 1'b0);
        check_ca(48'hA000_0000_0000, 1'b0);
        count_state(4'd3, n);
        check_eq("to_latency_len", n, 32'd2);
        for (int i = 0; i < 2; i++) begin
            rx_valid_i = 1'b1; rx_data_i = 8'h70 + 8'(i);
            #1;
            check_eq("to_rd_data", {24'd0, rx_data_o}, 32'h70 + i);
            check_eq("to_rd_last", {31'd0, rx_last_o}, 32'd0);
            @(negedge clk_phy_i);
            rx_valid_i = 1'b0;
        end
        count_state(4'd5, n);
        check_eq("timeout_len", n, 32'd64);
        finish_trans(1'b1);

        // reset in the middle of LATENCY
        cfg_latency_i = 4'd6;
        start_trans(1'b0, 1'b0, 32'h0000_1235, 8'd1, 1'b0);
        check_ca(48'hA000_0246_0005, 1'b0);
        repeat (3) @(negedge clk_phy_i);
        check_eq("pre_rst_state", {28'd0, debug_state_o}, 32'd3);
        rst_ni = 1'b0;
        @(negedge clk_phy_i);
        check_eq("mid_rst_cs", {30'd0, hyper_cs_no}, 32'd3);
        check_eq("mid_rst_state", {28'd0, debug_state_o}, 32'd0);
        check_eq("mid_rst_outs", {27'd0, done_o, hyper_ck_en_o, hyper_dq_oe_o, trans_ready_o, rx_valid_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_phy_i);
        check_eq("post_rst_ready", {31'd0, trans_ready_o}, 32'd1);
        check_eq("post_rst_done", {31'd0, done_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hyperbus_cmd_seq.md
Name: hyperbus_cmd_seq

Overview:
- Transaction sequencer sitting directly upstream of the HyperBus PHY pins, downstream of the AXI-to-transaction front end.
- Accepts one transaction at a time, asserts chip select, and serialises the 48-bit command-address (CA) word.
- Counts initial latency, honouring RWDS-signalled 2x latency, then streams write bytes out or read bytes in, and closes with CS hold/recovery timing.
- Byte-per-clock abstraction: one dq byte per clk_phy_i cycle. The DDR split is done in the PHY.

Parameters:
- NumChips, 2, number of chip selects.
- LenWidth, 8, width of the transaction length field.
- TimeoutCycles, 64, read-phase idle cycles before abort; must be ≥1.
- CsMinHighCycles, 4, minimum cycles CS stays high between transactions; must be ≥1.

Ports:
- clk_phy_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- cfg_latency_i  in  4  initial latency in HyperBus clocks (L).
- cfg_latency_fixed_i  in  1  1 = always apply 2x latency.
- trans_valid_i / trans_ready_o  in/out  1  transaction handshake.
- trans_write_i  in  1  1 = write.
- trans_addr_space_i  in  1  1 = register space.
- trans_burst_linear_i  in  1  1 = linear, 0 = wrapped.
- trans_addr_i  in  32  half-word address.
- trans_len_i  in  LenWidth  number of 16-bit words minus one.
- trans_cs_sel_i  in  $clog2(NumChips)  target chip.
- tx_valid_i / tx_ready_o  in/out  1  write byte stream.
- tx_data_i  in  8  write byte.
- tx_mask_i  in  1  1 = byte masked.
- rx_valid_i  in  1  captured read byte valid (from RWDS capture).
- rx_data_i  in  8  captured read byte.
- rx_valid_o  out  1  read byte out; no backpressure.
- rx_data_o  out  8  read byte out.
- rx_last_o  out  1  last read byte of the transaction.
- done_o  out  1  one-cycle pulse at transaction end.
- done_error_o  out  1  qualifies done_o; read timeout occurred.
- hyper_cs_no  out  NumChips  active-low chip selects.
- hyper_ck_en_o  out  1  PHY clock enable.
- hyper_dq_o  out  8  dq output.
- hyper_dq_oe_o  out  1  dq output enable.
- hyper_rwds_o  out  1  rwds output.
- hyper_rwds_oe_o  out  1  rwds output enable.
- hyper_rwds_i  in  1  rwds input.
- debug_state_o  out  4  current FSM state encoding.

Behaviour:
- Reset: synchronous, active-low; all outputs 0 except hyper_cs_no = all-ones. FSM goes to IDLE. Reset mid-transaction drops CS on the next edge with no done_o.
- CA format:
  - CA[47] = ~write
  - CA[46] = addr_space
  - CA[45] = burst_linear
  - CA[44:16] = addr[31:3]
  - CA[15:3] = 0
  - CA[2:0] = addr[2:0]
  - Bytes are sent CA[47:40] first.
- IDLE: trans_ready_o = 1. On handshake, latch all trans_* fields; byte count B = 2*(len+1). Go to CS_SETUP.
- CS_SETUP (1 cycle): the selected CS goes low; dq/rwds are not driven; ck_en = 0.
- CA (6 cycles): dq_oe = 1, ck_en = 1, byte k driven in cycle k. Sample hyper_rwds_i in CA cycle 2; double = sample | cfg_latency_fixed_i.
- After CA:
  - Register-space write → WDATA directly, with zero latency.
  - Otherwise → LATENCY, with count W = 2*L, doubled to 4*L if double; W = 0 skips LATENCY.
- LATENCY: dq_oe = 0, ck_en = 1; count down W cycles. Then go to WDATA or RDATA.
- WDATA:
  - tx_ready_o = 1.
  - Per accepted byte: dq_o = tx_data_i, dq_oe = 1, ck_en = 1.
  - rwds_oe = 1 and rwds_o = tx_mask_i, except for register writes, where rwds_oe = 0.
  - tx_valid_i low: stall, ck_en = 0, dq held.
  - After B bytes → CS_HOLD.
- RDATA:
  - ck_en = 1; each rx_valid_i forwards to rx_valid_o/rx_data_o in the same cycle; rx_last_o on byte B.
  - Idle counter clears on each rx_valid_i. Reaching TimeoutCycles sets the error flag and goes to CS_HOLD; remaining bytes are not emitted.
  - rx_valid_i outside RDATA is ignored.
- CS_HOLD (1 cycle): ck_en = 0, CS still low, outputs disabled. done_o pulses, with done_error_o = error flag.
- CS_RECOVER: all CS high for CsMinHighCycles, then IDLE. trans_ready_o = 0 until IDLE.
- Counter widths: byte counter LenWidth+2 bits; latency counter 6 bits. len = max is legal.
- debug_state_o encoding: IDLE = 0, CS_SETUP = 1, CA = 2, LATENCY = 3, WDATA = 4, RDATA = 5, CS_HOLD = 6, CS_RECOVER = 7.

Test Plan:
- Memory read, addr = 0x0000_1235, len = 1, linear, L = 6, rwds low in CA → CA bytes A0 00 02 46 00 05; 12 latency cycles; 4 rx bytes forwarded, rx_last_o on the 4th; done_o with done_error_o = 0.
- Same read with hyper_rwds_i high at CA cycle 2 → 24 latency cycles. With cfg_latency_fixed_i = 1 and rwds low → also 24.
- Memory write, len = 0, tx_valid_i gapped for 3 cycles mid-burst → ck_en = 0 during the gap; rwds_o follows tx_mask_i; CS high for 4 cycles after done_o.
- Register write (addr_space = 1) → WDATA starts the cycle after CA byte 5; no LATENCY; rwds_oe = 0.
- Read, len = 3, only 2 rx bytes then silence → after 64 idle cycles done_o = 1 with done_error_o = 1; rx_last_o never asserted.
- rst_ni low during LATENCY → next cycle CS all-ones, all outputs 0, trans_ready_o = 1 after release; no done_o.
